// File: rtl/fpu_result_capture_if.sv
// rtl/fpu_result_capture_if.sv - result stream from the capture FIFO to the host
interface fpu_result_capture_if #(
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic [3:0]    out_status;
    logic [CW-1:0] out_count;
    logic          overrun;

    modport master (
        output out_valid,
        output out_data,
        output out_status,
        output out_count,
        output overrun,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_status,
        input  out_count,
        input  overrun,
        output out_ready
    );
endinterface

// File: rtl/fpu_result_capture.sv
// rtl/fpu_result_capture.sv - settle-detect FPU results, convert to binary32, queue in FIFO
module fpu_result_capture #(
    parameter int STABLE_CYCLES = 16,
    parameter int DEPTH         = 4
) (
    input  logic                  clock100KHz,
    input  logic                  reset,
    input  logic [31:0]           data_in,
    input  logic [3:0]            status_in,
    fpu_result_capture_if.master  res
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [7:0]    CNT_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0]    CAP_AT  = 8'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);

    logic [35:0]   prev_q, prev_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          armed_q, armed_d;
    logic [35:0]   mem_q [DEPTH];
    logic [35:0]   mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          overrun_q, overrun_d;

    logic          match;
    logic          capture;
    logic          push;
    logic          pop;
    logic [31:0]   conv_word;

    assign match   = ({data_in, status_in} == prev_q);
    assign capture = match && armed_q && (cnt_q == CAP_AT);
    assign pop     = (count_q != '0) && res.out_ready;
    assign push    = capture && ((count_q < FULL) || pop);

    // FPU format {s, e[5:0] bias 31, m[24:0]} to binary32, round-to-nearest-even on m[1:0]
    always_comb begin
        logic        s;
        logic [5:0]  e;
        logic [24:0] m;
        logic [3:0]  st;
        logic        round_up;
        logic [23:0] frac;
        logic [7:0]  expo;
        s        = prev_q[35];
        e        = prev_q[34:29];
        m        = prev_q[28:4];
        st       = prev_q[3:0];
        round_up = m[1] & (m[0] | m[2]);
        frac     = {1'b0, m[24:2]} + {23'd0, round_up};
        expo     = {2'b00, e} + 8'd96;
        if (frac[23]) begin
            expo = expo + 8'd1;
        end
        if (st[2]) begin
            conv_word = {s, 8'hFF, 23'd0};
        end else if (st[1] || (e == 6'd0 && m == 25'd0)) begin
            conv_word = {s, 31'd0};
        end else begin
            conv_word = {s, expo, frac[22:0]};
        end
    end

    always_comb begin
        prev_d = {data_in, status_in};

        cnt_d = cnt_q;
        if (!match) begin
            cnt_d = 8'd0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end

        // armed stops a long-held value from being queued a second time
        armed_d = armed_q;
        if (!match) begin
            armed_d = 1'b1;
        end else if (capture) begin
            armed_d = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        wr_d      = wr_q;
        rd_d      = rd_q;
        count_d   = count_q;
        overrun_d = overrun_q | (capture & ~push);
        if (push) begin
            mem_d[wr_q] = {conv_word, prev_q[3:0]};
            wr_d        = wr_q + AW'(1);
        end
        if (pop) begin
            rd_d = rd_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            prev_q    <= '0;
            cnt_q     <= '0;
            armed_q   <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    assign res.out_valid  = (count_q != '0);
    assign res.out_data   = res.out_valid ? mem_q[rd_q][35:4] : 32'd0;
    assign res.out_status = res.out_valid ? mem_q[rd_q][3:0] : 4'd0;
    assign res.out_count  = count_q;
    assign res.overrun    = overrun_q;
endmodule

// File: tb/tb_fpu_result_capture.sv
// tb/tb_fpu_result_capture.sv - randomized bench for fpu_result_capture with queue reference model
module tb_fpu_result_capture;
    localparam int S     = 16;
    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic [31:0] data_in;
    logic [3:0]  status_in;

    fpu_result_capture_if #(.DEPTH(DEPTH)) bus ();

    fpu_result_capture #(.STABLE_CYCLES(S), .DEPTH(DEPTH)) dut (
        .clock100KHz (clk),
        .reset       (reset),
        .data_in     (data_in),
        .status_in   (status_in),
        .res         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    bit          chk_en = 0;
    logic [35:0] q[$];
    logic [35:0] m_val;
    int          m_run;
    bit          m_ovr;

    function automatic logic [31:0] pack(input bit s, input int e, input int unsigned m);
        logic [5:0]  e6;
        logic [24:0] m25;
        e6  = e[5:0];
        m25 = m[24:0];
        return {s, e6, m25};
    endfunction

    function automatic logic [31:0] conv(input logic [31:0] d, input logic [3:0] st);
        int          e;
        int          frac;
        int          rem;
        logic [7:0]  e8;
        logic [22:0] f23;
        e    = int'(d[30:25]);
        frac = int'(d[24:0]) / 4;
        rem  = int'(d[24:0]) % 4;
        if (st[2]) return {d[31], 8'hFF, 23'd0};
        if (st[1] || (e == 0 && d[24:0] == 25'd0)) return {d[31], 31'd0};
        if (rem > 2 || (rem == 2 && (frac % 2) == 1)) frac = frac + 1;
        e = e + 96;
        if (frac == (1 << 23)) begin
            frac = 0;
            e    = e + 1;
        end
        e8  = e[7:0];
        f23 = frac[22:0];
        return {d[31], e8, f23};
    endfunction

    // Per-edge scoreboard against the queue model
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            n_vec++;
            if (bus.out_valid !== (q.size() > 0)) begin
                n_err++;
                $display("FAIL sb_valid t=%0t got %b want %b", $time, bus.out_valid, q.size() > 0);
            end
            n_vec++;
            if (bus.out_count !== 3'(q.size())) begin
                n_err++;
                $display("FAIL sb_count t=%0t got %0d want %0d", $time, bus.out_count, q.size());
            end
            n_vec++;
            if (bus.overrun !== m_ovr) begin
                n_err++;
                $display("FAIL sb_overrun t=%0t got %b want %b", $time, bus.overrun, m_ovr);
            end
            if (q.size() > 0) begin
                n_vec++;
                if ({bus.out_data, bus.out_status} !== q[0]) begin
                    n_err++;
                    $display("FAIL sb_head t=%0t got %h/%h want %h/%h", $time,
                             bus.out_data, bus.out_status, q[0][35:4], q[0][3:0]);
                end
            end
        end
    end

    // One clock: drive at negedge, advance the model, return after the edge settles
    task automatic step(input logic [31:0] d, input logic [3:0] st, input bit rdy);
        logic [35:0] v;
        bit          cap;
        bit          pop;
        @(negedge clk);
        data_in       = d;
        status_in     = st;
        bus.out_ready = rdy;
        v = {d, st};
        if (v !== m_val) begin
            m_val = v;
            m_run = 0;
        end
        m_run++;
        cap = (m_run == S + 1);
        pop = rdy && (q.size() > 0);
        if (pop) void'(q.pop_front());
        if (cap) begin
            if (q.size() < DEPTH) q.push_back({conv(d, st), st});
            else m_ovr = 1;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic hold(input logic [31:0] d, input logic [3:0] st, input bit rdy, input int n);
        for (int i = 0; i < n; i++) step(d, st, rdy);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((q.size() > 0 || m_run <= S) && guard < 60) begin
            step(m_val[35:4], m_val[3:0], 1'b1);
            guard++;
        end
    endtask

    task automatic do_reset();
        chk_en = 0;
        @(negedge clk);
        reset         = 1'b0;
        data_in       = 32'd0;
        status_in     = 4'd0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_vec++;
        if ({bus.out_valid, bus.out_data, bus.out_status, bus.out_count, bus.overrun} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got v=%b d=%h s=%h c=%0d o=%b want all zero",
                     bus.out_valid, bus.out_data, bus.out_status, bus.out_count, bus.overrun);
        end
        @(negedge clk);
        reset = 1'b1;
        q.delete();
        m_val = '0;
        m_run = 1;
        m_ovr = 0;
        @(posedge clk);
        m_run = 2;
        chk_en = 1;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_basic();
        hold(pack(0, 31, 0), 4'b1000, 1'b0, S);
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL latency_early got valid=%b want 0", bus.out_valid);
        end
        step(pack(0, 31, 0), 4'b1000, 1'b0);
        n_vec++;
        if ({bus.out_valid, bus.out_data, bus.out_status, bus.out_count} !== {1'b1, 32'h3F800000, 4'b1000, 3'd1}) begin
            n_err++;
            $display("FAIL first_capture got v=%b d=%h s=%h c=%0d want 1/3f800000/8/1",
                     bus.out_valid, bus.out_data, bus.out_status, bus.out_count);
        end
        hold(pack(1, 32, 0), 4'b1000, 1'b0, 20);
        step(pack(1, 32, 0), 4'b1000, 1'b1);
        n_vec++;
        if (bus.out_data !== 32'hC0000000) begin
            n_err++;
            $display("FAIL neg_two got %h want c0000000", bus.out_data);
        end
        hold(pack(0, 33, 0), 4'b1000, 1'b0, 100);
        n_vec++;
        if (bus.out_count !== 3'd2) begin
            n_err++;
            $display("FAIL no_duplicate got count %0d want 2", bus.out_count);
        end
        drain();
    endtask

    task automatic test_rounding();
        logic [31:0] vals [4];
        logic [31:0] want [4];
        vals[0] = pack(0, 31, 25'h1FFFFFF); want[0] = 32'h40000000;
        vals[1] = pack(0, 31, 25'h0000002); want[1] = 32'h3F800000;
        vals[2] = pack(0, 31, 25'h0000006); want[2] = 32'h3F800002;
        vals[3] = 32'd0;                    want[3] = 32'h00000000;
        for (int i = 0; i < 4; i++) begin
            hold(vals[i], 4'b0001, 1'b0, S + 1);
            n_vec++;
            if (bus.out_data !== want[i]) begin
                n_err++;
                $display("FAIL rounding_%0d got %h want %h", i, bus.out_data, want[i]);
            end
            drain();
        end
    endtask

    task automatic test_special();
        hold(pack(0, 63, 25'h1FFFFFF), 4'b0100, 1'b0, S + 1);
        n_vec++;
        if (bus.out_data !== 32'h7F800000) begin
            n_err++;
            $display("FAIL overflow_inf got %h want 7f800000", bus.out_data);
        end
        drain();
        hold(pack(1, 10, 5), 4'b0010, 1'b0, S + 1);
        n_vec++;
        if (bus.out_data !== 32'h80000000) begin
            n_err++;
            $display("FAIL underflow_zero got %h want 80000000", bus.out_data);
        end
        drain();
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [3:0]  st;
        for (int i = 0; i < 40; i++) begin
            d  = $urandom;
            st = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) st = st & 4'b1001;
            hold(d, st, 1'($urandom_range(0, 1)), $urandom_range(1, S + 4));
        end
        drain();
    endtask

    task automatic test_fifo_full();
        logic [31:0] vals [5];
        do_reset();
        for (int i = 0; i < 5; i++) begin
            vals[i] = pack(0, 10 + i, $urandom);
            hold(vals[i], 4'b0001, 1'b0, S + 2);
        end
        n_vec++;
        if ({bus.out_count, bus.overrun} !== {3'd4, 1'b1}) begin
            n_err++;
            $display("FAIL full_overrun got count %0d ovr %b want 4/1", bus.out_count, bus.overrun);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if ({bus.out_valid, bus.out_data} !== {1'b1, conv(vals[i], 4'b0001)}) begin
                n_err++;
                $display("FAIL full_order_%0d got %b/%h want 1/%h", i, bus.out_valid, bus.out_data,
                         conv(vals[i], 4'b0001));
            end
            step(vals[4], 4'b0001, 1'b1);
        end
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL full_drained got valid %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_toggle();
        logic [31:0] a;
        logic [31:0] b;
        a = pack(0, 20, $urandom);
        b = pack(1, 21, $urandom);
        for (int i = 0; i < 200 / (S - 1); i++) begin
            hold((i % 2 == 0) ? a : b, 4'b0001, 1'b0, S - 1);
        end
        n_vec++;
        if (bus.out_count !== 3'd0) begin
            n_err++;
            $display("FAIL toggle_no_capture got count %0d want 0", bus.out_count);
        end
    endtask

    task automatic test_async_reset();
        hold(pack(0, 40, 7), 4'b1000, 1'b0, S + 1);
        hold(pack(0, 41, 9), 4'b1000, 1'b0, S + 1);
        hold(pack(0, 42, 3), 4'b1000, 1'b0, 5);
        n_vec++;
        if (bus.out_count !== 3'd2) begin
            n_err++;
            $display("FAIL async_setup got count %0d want 2", bus.out_count);
        end
        chk_en = 0;
        #1;
        reset = 1'b0;
        #1;
        n_vec++;
        if ({bus.out_valid, bus.out_count, bus.out_data} !== '0) begin
            n_err++;
            $display("FAIL async_reset got v=%b c=%0d d=%h want 0/0/0", bus.out_valid, bus.out_count, bus.out_data);
        end
    endtask

    initial begin
        reset         = 1'b0;
        data_in       = 32'd0;
        status_in     = 4'd0;
        bus.out_ready = 1'b0;
        m_val         = '0;
        m_run         = 0;
        m_ovr         = 0;
        test_reset();
        test_basic();
        test_rounding();
        test_special();
        test_random();
        test_fifo_full();
        drain();
        test_toggle();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
